// File: rtl/edge_window_gen.sv
// Streaming 4-neighbour window builder for the Sobel-cross edge kernel.
// Two line buffers plus short tap shift registers give one {up,right,down,left} window per interior pixel.
module edge_window_gen #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int XW     = 10,
  parameter int YW     = 9
) (
  input  logic          clock,
  input  logic          nReset,
  input  logic          frame_start,
  input  logic          pixel_valid,
  input  logic [7:0]    pixel_in,
  output logic          window_valid,
  output logic [31:0]   window_out,
  output logic [XW-1:0] x_out,
  output logic [YW-1:0] y_out,
  output logic          frame_done,
  output logic          overrun
);

  localparam logic [XW-1:0] COL_LAST = XW'(WIDTH - 1);
  localparam logic [YW-1:0] ROW_LAST = YW'(HEIGHT - 1);

  logic [7:0]    lb1_mem [WIDTH];
  logic [7:0]    lb2_mem [WIDTH];

  logic [XW-1:0] col_r;
  logic [YW-1:0] row_r;
  logic          frame_full_r;
  logic          overrun_r;

  logic          accept_s;
  logic [XW-1:0] pos_col_s;
  logic [YW-1:0] pos_row_s;

  logic          v1_r;
  logic          complete1_r;
  logic          last1_r;
  logic [7:0]    pix1_r;
  logic [7:0]    up1_r;
  logic [7:0]    mid1_r;
  logic [XW-1:0] x1_r;
  logic [YW-1:0] y1_r;

  logic [7:0]    pix_d1_r;
  logic [7:0]    up_d1_r;
  logic [7:0]    mid_d1_r;
  logic [7:0]    mid_d2_r;

  assign overrun = overrun_r;

  // Acceptance and position of the current pixel; frame_start redirects it to (0,0).
  always_comb begin
    accept_s  = pixel_valid & (frame_start | ~frame_full_r);
    pos_col_s = col_r;
    pos_row_s = row_r;
    if (frame_start) begin
      pos_col_s = {XW{1'b0}};
      pos_row_s = {YW{1'b0}};
    end else begin
      pos_col_s = col_r;
      pos_row_s = row_r;
    end
  end

  // Raster position counters, frame-full flag and sticky overrun.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      col_r        <= {XW{1'b0}};
      row_r        <= {YW{1'b0}};
      frame_full_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (frame_start) begin
      col_r        <= pixel_valid ? XW'(1) : {XW{1'b0}};
      row_r        <= {YW{1'b0}};
      frame_full_r <= 1'b0;
      overrun_r    <= 1'b0;
    end else if (pixel_valid && frame_full_r) begin
      overrun_r <= 1'b1;
    end else if (pixel_valid) begin
      if (col_r == COL_LAST) begin
        col_r <= {XW{1'b0}};
        if (row_r == ROW_LAST) begin
          frame_full_r <= 1'b1;
        end else begin
          row_r <= row_r + YW'(1);
        end
      end else begin
        col_r <= col_r + XW'(1);
      end
    end
  end

  // Line buffers with read-first synchronous read; LB2 inherits the old LB1 entry.
  always_ff @(posedge clock) begin
    if (accept_s) begin
      up1_r              <= lb2_mem[pos_col_s];
      mid1_r             <= lb1_mem[pos_col_s];
      lb2_mem[pos_col_s] <= lb1_mem[pos_col_s];
      lb1_mem[pos_col_s] <= pixel_in;
    end
  end

  // Stage 1: carry the accepted pixel and its window bookkeeping alongside the RAM read.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      v1_r        <= 1'b0;
      complete1_r <= 1'b0;
      last1_r     <= 1'b0;
      pix1_r      <= 8'd0;
      x1_r        <= {XW{1'b0}};
      y1_r        <= {YW{1'b0}};
    end else begin
      v1_r <= accept_s;
      if (accept_s) begin
        pix1_r      <= pixel_in;
        complete1_r <= (pos_row_s >= YW'(2)) && (pos_col_s >= XW'(2));
        last1_r     <= (pos_row_s == ROW_LAST) && (pos_col_s == COL_LAST);
        x1_r        <= pos_col_s - XW'(1);
        y1_r        <= pos_row_s - YW'(1);
      end
    end
  end

  // Stage 2: tap shift registers and registered window outputs; frame_start kills stage 1.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      pix_d1_r     <= 8'd0;
      up_d1_r      <= 8'd0;
      mid_d1_r     <= 8'd0;
      mid_d2_r     <= 8'd0;
      window_valid <= 1'b0;
      window_out   <= 32'd0;
      x_out        <= {XW{1'b0}};
      y_out        <= {YW{1'b0}};
      frame_done   <= 1'b0;
    end else if (frame_start) begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end else if (v1_r) begin
      pix_d1_r     <= pix1_r;
      up_d1_r      <= up1_r;
      mid_d1_r     <= mid1_r;
      mid_d2_r     <= mid_d1_r;
      window_valid <= complete1_r;
      frame_done   <= complete1_r & last1_r;
      if (complete1_r) begin
        window_out <= {up_d1_r, mid1_r, pix_d1_r, mid_d2_r};
        x_out      <= x1_r;
        y_out      <= y1_r;
      end
    end else begin
      window_valid <= 1'b0;
      frame_done   <= 1'b0;
    end
  end

endmodule

// File: doc/edge_window_gen.md
Name: edge_window_gen

Overview:
- Streaming writer for the Sobel-cross edge kernel. Accepts one 8-bit grayscale pixel per valid cycle from the camera path, in raster order.
- Keeps the two previous image lines in internal line buffers.
- Emits, for every interior pixel, a packed 4-neighbour window {up, right, down, left}. This window is exactly the 32-bit block_in format consumed by the thresholded edge kernel.
- Sits between the camera grayscale converter and the edge-threshold kernel.

Parameters:
- WIDTH, 640, pixels per line (≥3).
- HEIGHT, 480, lines per frame (≥3).
- XW, 10, width of column counter/coordinate (2^XW ≥ WIDTH).
- YW, 9, width of row counter/coordinate (2^YW ≥ HEIGHT).

Ports:
- clock  in  1  system clock, all state on rising edge.
- nReset  in  1  asynchronous active-low reset.
- frame_start  in  1  single-cycle pulse; the next accepted pixel is row 0, col 0.
- pixel_valid  in  1  pixel_in is valid this cycle (no backpressure, gaps allowed).
- pixel_in  in  8  grayscale pixel.
- window_valid  out  1  window_out/x_out/y_out valid this cycle.
- window_out  out  32  [31:24] up, [23:16] right, [15:8] down, [7:0] left.
- x_out  out  XW  column of window centre pixel.
- y_out  out  YW  row of window centre pixel.
- frame_done  out  1  pulse coincident with the last window of a frame.
- overrun  out  1  sticky; pixels received after a full frame.

Behaviour:
- Reset (nReset low, async):
  - Outputs: window_valid=0, window_out=0, x_out=0, y_out=0, frame_done=0, overrun=0.
  - Counters: col=0, row=0, frame_full=0.
  - Line buffer contents are don't-care.
- Accepting a pixel:
  - A pixel is accepted when pixel_valid=1 and frame_full=0. It is assigned position (row, col).
  - col increments. At col=WIDTH-1 it wraps to 0 and row increments.
  - Accepting (HEIGHT-1, WIDTH-1) sets frame_full.
- Line buffers:
  - LB1 holds row r-1; LB2 holds row r-2.
  - On acceptance at column c: LB2[c] ← old LB1[c], LB1[c] ← pixel_in.
  - Read is synchronous (block-RAM friendly).
- Window formation:
  - Acceptance of pixel (r, c) with r≥2 and c≥2 completes the window centred at (r-1, c-1):
    - up = (r-2, c-1)
    - right = (r-1, c)
    - down = (r, c-1)
    - left = (r-1, c-2)
  - Column-adjacent taps are held in shift registers that advance only on accepted pixels.
- Latency and rate:
  - Latency is fixed at 2 cycles: pixel accepted at cycle k → window_valid=1 at cycle k+2 with x_out=c-1, y_out=r-1.
  - Pipeline is fully pipelined: back-to-back pixels give back-to-back windows.
  - Input gaps propagate as window_valid=0 gaps; latency is unchanged.
- Window count and order:
  - No windows for border centres (row 0, row HEIGHT-1, col 0, col WIDTH-1).
  - Exactly (HEIGHT-2)*(WIDTH-2) windows per frame, in raster order of centre.
- Output hold: window_out/x_out/y_out hold their last value when window_valid=0.
- frame_done: asserted for 1 cycle with the window centred at (HEIGHT-2, WIDTH-2).
- Frame full / overrun:
  - While frame_full=1, pixel_valid pixels are dropped and set overrun (sticky).
  - frame_start clears overrun and frame_full.
- frame_start handling:
  - frame_start resets row/col to 0 and clears frame_full and overrun.
  - It also invalidates any in-flight pipeline stage, so no window from the old frame is emitted after frame_start.
  - frame_start together with pixel_valid in the same cycle: that pixel is accepted as (0, 0) of the new frame.
  - frame_start mid-frame aborts the frame; no frame_done is generated for it.
  - Stale line-buffer data is never emitted, because windows only start at r≥2 after both lines are rewritten.
- Reset mid-frame: all state returns to reset values immediately; the first pixel after reset release and frame_start is (0, 0).
- Arithmetic: no arithmetic on pixel data; pixels are passed through unmodified, unsigned 8-bit.

Test Plan:
- Basic window, first and last:
  - Stimulus: WIDTH=8, HEIGHT=4; frame_start, then 32 back-to-back pixels with value (r*16+c).
  - First window at 2 cycles after pixel (2,2): window_out=0x01122110, x_out=1, y_out=1.
  - Last window: window_out=0x16273625, x_out=6, y_out=2, with frame_done=1.
- Window count: same frame → exactly 12 window_valid pulses, in raster order. No windows for x_out∈{0,7} or y_out∈{0,3}.
- Input gaps: same frame with pixel_valid random 50% duty → identical window sequence. Each window appears exactly 2 cycles after its completing pixel.
- Overrun: 35 pixels after one frame_start → windows as in the basic-window scenario. overrun rises after pixel 33. A following frame_start clears overrun to 0.
- Abort mid-frame: frame_start asserted with pixel_valid at pixel (2,4) of frame A → no A-window after that cycle, no frame_done for A. The new frame produces 12 correct windows.
- Reset mid-frame: nReset low during row 2 → all outputs 0 asynchronously. After release plus frame_start, a full frame is reproduced exactly as in the basic-window scenario.
